// File: rtl/bidiag_pkg.sv
// Shared widths, FSM state encoding and sample/index helpers for the bidiagonalization link.
package bidiag_pkg;

  localparam int unsigned BIT_NUM      = 18;
  localparam int unsigned DIM          = 4;
  localparam int unsigned CHANNEL_SIZE = DIM * DIM;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned WCNT_W       = 8;
  localparam int unsigned RX_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  typedef struct packed {
    logic [BIT_NUM-1:0] re;
    logic [BIT_NUM-1:0] im;
  } cplx_t;

  // Row-major packing of a matrix coordinate into a buffer index.
  function automatic logic [IDX_W-1:0] rc_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/cplx_buf16.sv
// 16-entry complex register file: one synchronous write port, one combinational read port.
module cplx_buf16
  import bidiag_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  cplx_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output cplx_t            rdata
);

  cplx_t mem [CHANNEL_SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNEL_SIZE); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bidiag_link.sv
// Host-side link: streams a 16-sample channel matrix to the core and captures its 16-sample result.
// Optional RX timeout is compiled in with BIDIAG_LINK_TIMEOUT_EN.
module bidiag_link
  import bidiag_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               host_we,
  input  logic [IDX_W-1:0]   host_addr,
  input  logic [BIT_NUM-1:0] host_wr_re,
  input  logic [BIT_NUM-1:0] host_wr_im,
  output logic [BIT_NUM-1:0] host_rd_re,
  output logic [BIT_NUM-1:0] host_rd_im,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               tx_valid_o,
  output logic [BIT_NUM-1:0] tx_R_o,
  output logic [BIT_NUM-1:0] tx_I_o,
  input  logic               rx_valid_i,
  input  logic [BIT_NUM-1:0] rx_R_i,
  input  logic [BIT_NUM-1:0] rx_I_i
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;
  cplx_t            tx_rd;
  cplx_t            rx_rd;
  logic             tx_we;
  logic             rx_we;
  logic [IDX_W-1:0] rx_waddr;

`ifdef BIDIAG_LINK_TIMEOUT_EN
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RX_TIMEOUT - 1);
  logic [WCNT_W-1:0] wcnt;
`endif

  // TX buffer is host-writable only while idle; RX buffer only fills during WAIT/CAPTURE.
  assign tx_we    = host_we && (state == IDLE);
  assign rx_we    = rx_valid_i && ((state == WAIT) || (state == CAPTURE));
  assign rx_waddr = (state == WAIT) ? '0 : rcnt[IDX_W-1:0];

  cplx_buf16 u_tx_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (tx_we),
    .waddr (host_addr),
    .wdata ('{re: host_wr_re, im: host_wr_im}),
    .raddr (cnt[IDX_W-1:0]),
    .rdata (tx_rd)
  );

  cplx_buf16 u_rx_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (rx_we),
    .waddr (rx_waddr),
    .wdata ('{re: rx_R_i, im: rx_I_i}),
    .raddr (host_addr),
    .rdata (rx_rd)
  );

  assign host_rd_re = rx_rd.re;
  assign host_rd_im = rx_rd.im;

  // cnt is 0 in IDLE, so the TX read port already presents sample 0 when start arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_R_o     <= '0;
      tx_I_o     <= '0;
`ifdef BIDIAG_LINK_TIMEOUT_EN
      wcnt       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SEND;
            busy       <= 1'b1;
            err        <= 1'b0;
            cnt        <= CNT_W'(1);
            rcnt       <= '0;
            tx_valid_o <= 1'b1;
            tx_R_o     <= tx_rd.re;
            tx_I_o     <= tx_rd.im;
          end
        end
        SEND: begin
          if (cnt == CNT_W'(CHANNEL_SIZE)) begin
            state      <= WAIT;
            tx_valid_o <= 1'b0;
            cnt        <= '0;
`ifdef BIDIAG_LINK_TIMEOUT_EN
            wcnt       <= '0;
`endif
          end else begin
            tx_R_o <= tx_rd.re;
            tx_I_o <= tx_rd.im;
            cnt    <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (rx_valid_i) begin
            state <= CAPTURE;
            rcnt  <= CNT_W'(1);
          end
`ifdef BIDIAG_LINK_TIMEOUT_EN
          else if (wcnt >= WAIT_LAST) begin
            state <= DONE;
            err   <= 1'b1;
            done  <= 1'b1;
          end else if (wcnt != '1) begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        CAPTURE: begin
          if (rx_valid_i) begin
            rcnt <= rcnt + 1'b1;
            if (rcnt == CNT_W'(CHANNEL_SIZE - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= DONE;
            err   <= 1'b1;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
